vec_tan: RTL
============

Name: vec_tan

Overview:
Upstream feeder for the arctan stage. Takes a signed Cartesian vector (x, y), e.g. an accelerometer or magnetometer axis pair, and computes tan = y/x using a self-contained serial restoring divider. The result is sign-magnitude Q16.16 in the exact format arctan consumes on its tan input. The tan output is held stable between results, because arctan restarts its iteration whenever tan changes.

Parameters:
IN_W, 16, width of the signed two's-complement in_x/in_y inputs; legal range 2..16.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input vector offered
in_ready  output  1  high only in IDLE; a transfer occurs when in_valid && in_ready at a rising edge
in_x  input  IN_W  signed x component
in_y  input  IN_W  signed y component
valid  output  1  one-cycle pulse when tan/quadrant/div_zero/sat update
tan  output  32  bit31 = sign; [30:0] = |y|/|x| in Q16.16; held until the next result
quadrant  output  2  0: x>=0,y>=0; 1: x<0,y>=0; 2: x<0,y<0; 3: x>=0,y<0
div_zero  output  1  last result had x==0
sat  output  1  last result had its magnitude clipped to 0x7FFFFFFF
busy  output  1  high in DIV and DONE

Behaviour:
- Reset (async, any state, including mid-division): state=IDLE, valid=0, tan=0, quadrant=0, div_zero=0, sat=0, busy=0, in_ready=1. Internal divider registers are cleared and the partial result is discarded.
- States are IDLE, DIV and DONE.
- IDLE -> DIV on a transfer. At the transfer edge the block latches:
  - |x| and |y| as unsigned (IN_W) bits, so -2^(IN_W-1) is handled.
  - x_neg and y_neg.
  - dividend D = |y|<<16, zero-extended to 32 bits.
  - divisor V = |x|.
- DIV runs a restoring shift-subtract loop, one quotient bit per cycle, MSB first, for exactly N=32 iterations (33 with ROUND_EN).
  - Remainder register is IN_W+1 bits.
  - Iteration counter runs 0..N-1; DIV -> DONE after the last iteration.
- The loop runs even when V==0, so latency is data-independent. The quotient from a V==0 run is discarded.
- DONE, registered at the exit edge:
  - Magnitude Q: if V==0, Q=0 when |y|==0, otherwise Q=0x7FFFFFFF with div_zero=1.
  - Otherwise, if quotient > 0x7FFFFFFF, Q=0x7FFFFFFF and sat=1. Else Q=quotient and sat=0.
  - tan = {x_neg ^ y_neg, Q[30:0]}. y==0 is never negative, so x<0,y==0 gives 0x80000000 (arctan maps this to 180 deg). This is intentional.
  - quadrant is set per the table in Ports.
  - valid=1 for this single cycle. Next state is IDLE.
- Latency: the transfer at edge E gives valid high after edge E+33 (E+34 with ROUND_EN).
- Throughput: one vector per 34 cycles; no pipelining.
- in_valid during DIV or DONE is ignored, because in_ready=0. No input is queued.
- in_x/in_y are sampled only at the transfer edge; later changes have no effect on the current result.
- Between results, tan, quadrant, div_zero and sat hold their last values. A new result rewrites tan every time, even if the value is identical.

Optional Feature:
VEC_TAN_ROUND_EN
- Defined:
  - The divider runs 33 iterations, producing one extra fractional bit r.
  - quotient = (q33>>1) + r, i.e. round half up.
  - Saturation is checked after rounding; latency becomes 34 cycles.
- Undefined: 32 iterations; quotient is truncated toward zero.

Test Plan:
- Reset, then x=3, y=4 -> valid pulse 33 cycles after the transfer; tan=0x00015555, quadrant=0, div_zero=0, sat=0. With ROUND_EN: 0x00015555, 34 cycles.
- x=-2, y=2 -> tan=0x80010000, quadrant=1. Then x=-2, y=0 -> tan=0x80000000, quadrant=1. Then x=0, y=0 -> tan=0, div_zero=0.
- x=0, y=-5 -> tan=0xFFFFFFFF, div_zero=1, quadrant=3.
- x=1, y=-32768 (IN_W=16) -> tan=0xFFFFFFFF, sat=1, quadrant=3.
- x=3, y=2 -> tan=0x0000AAAA with the macro undefined; 0x0000AAAB with VEC_TAN_ROUND_EN.
- Hold in_valid high through a run with changing in_x/in_y -> in_ready=0 during DIV/DONE, the result matches the vector sampled at the transfer edge, and a second transfer happens on the first IDLE cycle. Assert rst_n low at iteration 10 of a run -> outputs go to reset values immediately and no valid pulse is produced.

Source files
------------

// File: rtl/vec_tan.sv
// vec_tan: signed (x,y) to sign-magnitude Q16.16 tan = y/x via a serial restoring divider.
// Optional VEC_TAN_ROUND_EN: 33 iterations with a round-half-up quotient.
module vec_tan #(
  parameter int IN_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_x,
  input  logic [IN_W-1:0] in_y,
  output logic            valid,
  output logic [31:0]     tan,
  output logic [1:0]      quadrant,
  output logic            div_zero,
  output logic            sat,
  output logic            busy
);

`ifdef VEC_TAN_ROUND_EN
  localparam int N = 33;
`else
  localparam int N = 32;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IN_W:0]   r_rem;
  logic [N-1:0]    r_dvd;
  logic [N-1:0]    r_quo;
  logic [5:0]      r_cnt;
  logic [IN_W-1:0] r_div;
  logic            r_yz;
  logic            r_xneg;
  logic            r_yneg;

  logic            r_valid;
  logic [31:0]     r_tan;
  logic [1:0]      r_quad;
  logic            r_dz;
  logic            r_sat;

  logic            w_xfer;
  logic            w_last;
  logic [IN_W-1:0] w_ax;
  logic [IN_W-1:0] w_ay;
  logic [31:0]     w_d32;
  logic [N-1:0]    w_dvd0;
  logic [IN_W+1:0] w_sub;
  logic            w_ge;
  logic [IN_W:0]   w_rem;
  logic            w_vz;
  logic            w_qsat;
  logic [30:0]     w_qlo;
  logic [30:0]     w_mag;
  logic            w_dz;
  logic            w_sat;

  assign w_xfer = in_valid & in_ready;
  assign w_last = (r_cnt == 6'(N - 1));

  // Unsigned magnitudes keep -2^(IN_W-1) exact.
  assign w_ax  = in_x[IN_W-1] ? ('0 - in_x) : in_x;
  assign w_ay  = in_y[IN_W-1] ? ('0 - in_y) : in_y;
  assign w_d32 = 32'(w_ay) << 16;

`ifdef VEC_TAN_ROUND_EN
  logic [32:0] w_qr;
  assign w_dvd0 = {w_d32, 1'b0};
  assign w_qr   = {1'b0, r_quo[N-1:1]} + 33'(r_quo[0]);
  assign w_qsat = w_qr[32] | w_qr[31];
  assign w_qlo  = w_qr[30:0];
`else
  assign w_dvd0 = w_d32;
  assign w_qsat = r_quo[31];
  assign w_qlo  = r_quo[30:0];
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_sub = {r_rem, r_dvd[N-1]} - {2'b00, r_div};
  assign w_ge  = ~w_sub[IN_W+1];
  assign w_rem = w_ge ? w_sub[IN_W:0]
                      : {r_rem[IN_W-1:0], r_dvd[N-1]};

  assign w_vz = (r_div == '0);

  always_comb begin
    w_mag = w_qlo;
    w_dz  = 1'b0;
    w_sat = 1'b0;
    unique case (1'b1)
      w_vz: begin
        w_mag = r_yz ? '0 : '1;
        w_dz  = ~r_yz;
      end
      (!w_vz && w_qsat): begin
        w_mag = '1;
        w_sat = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_DIV;
      S_DIV:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      S_IDLE:  in_ready = 1'b1;
      S_DIV:   busy = 1'b1;
      S_DONE:  busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_dvd  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_div  <= '0;
      r_yz   <= 1'b0;
      r_xneg <= 1'b0;
      r_yneg <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_xfer) begin
        r_rem  <= '0;
        r_dvd  <= w_dvd0;
        r_quo  <= '0;
        r_cnt  <= '0;
        r_div  <= w_ax;
        r_yz   <= (w_ay == '0);
        r_xneg <= in_x[IN_W-1];
        r_yneg <= in_y[IN_W-1];
      end
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem;
      r_dvd <= {r_dvd[N-2:0], 1'b0};
      r_quo <= {r_quo[N-2:0], w_ge};
      r_cnt <= r_cnt + 6'd1;
    end
  end

  // Results land as DONE exits, so valid coincides with the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tan   <= '0;
      r_quad  <= '0;
      r_dz    <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_tan  <= {r_xneg ^ r_yneg, w_mag};
        r_quad <= {r_yneg, r_xneg ^ r_yneg};
        r_dz   <= w_dz;
        r_sat  <= w_sat;
      end
    end
  end

  assign valid    = r_valid;
  assign tan      = r_tan;
  assign quadrant = r_quad;
  assign div_zero = r_dz;
  assign sat      = r_sat;

endmodule
